// File: rtl/mips_ctrl_pkg.sv
// mips_ctrl_pkg: state encodings, opcodes and control-field codes shared by the multi-cycle MIPS controller.
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_BEQ    = 4'd11,
        S_JUMP   = 4'd12,
        S_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_4     = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
    } ctrl_t;

endpackage

// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: opcode/memory handshake inputs and datapath control strobes between controller and datapath.
interface multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite;
    logic       Branch;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       MemtoReg;
    logic       RegDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] PCSrc;

    modport master (
        input  opcode, mem_ready,
        output PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc
    );

    modport slave (
        output opcode, mem_ready,
        input  PCWrite, Branch, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSrc
    );
endinterface

// File: rtl/multicycle_ctrl_outdec.sv
// multicycle_ctrl_outdec: combinational state -> control-word decoder; only FETCH looks at mem_ready.
module multicycle_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_read  = 1'b1;
                ctrl.alu_src_b = SRCB_4;
                ctrl.alu_op    = ALU_ADD;
                ctrl.pc_src    = PC_ALU;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.alu_src_b = SRCB_IMMSH;
            S_MEMADR, S_ADDIEX: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
            end
            S_MEMRD: begin
                ctrl.mem_read = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl.mem_write = 1'b1;
                ctrl.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_B;
                ctrl.alu_op    = ALU_FUNCT;
            end
            S_ALUWB: begin
                ctrl.reg_write = 1'b1;
                ctrl.reg_dst   = 1'b1;
            end
            S_ADDIWB: ctrl.reg_write = 1'b1;
            S_BEQ: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_op    = ALU_SUB;
                ctrl.branch    = 1'b1;
                ctrl.pc_src    = PC_ALUOUT;
            end
            S_JUMP: begin
                ctrl.pc_write = 1'b1;
                ctrl.pc_src   = PC_JUMP;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore FSM sequencing a multi-cycle MIPS datapath, with retired-instruction counter.
// Define MCCTRL_ILLEGAL_TRAP_EN to trap undefined opcodes (adds illegal_op); otherwise they retire silently as no-ops.
module multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus,
    output logic [CNT_W-1:0]   retired,
    output logic [3:0]         state_o
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    ,
    output logic               illegal_op
`endif
);

    state_t state, next;
    ctrl_t  ctrl;
    logic   retire;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            retired <= '0;
        end else begin
            state   <= next;
            retired <= retire ? retired + CNT_W'(1) : retired;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_IDLE:   next = S_FETCH;
            S_FETCH:  next = bus.mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: next = S_MEMADR;
                    OP_RTYPE:     next = S_EXEC;
                    OP_ADDI:      next = S_ADDIEX;
                    OP_BEQ:       next = S_BEQ;
                    OP_J:         next = S_JUMP;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
                    default:      next = S_TRAP;
`else
                    default:      next = S_FETCH;
`endif
                endcase
            end
            S_MEMADR: next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  next = bus.mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  next = bus.mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   next = S_ALUWB;
            S_ADDIEX: next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP: next = S_FETCH;
            S_TRAP:   next = S_TRAP;
            default:  next = S_IDLE;
        endcase
    end

    // An instruction retires on the edge that leaves its final state.
    assign retire = (state inside {S_MEMWB, S_ALUWB, S_ADDIWB, S_BEQ, S_JUMP}) ||
                    (state == S_MEMWR && bus.mem_ready);

    multicycle_ctrl_outdec u_outdec (
        .state     (state),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl)
    );

    assign bus.PCWrite  = ctrl.pc_write;
    assign bus.Branch   = ctrl.branch;
    assign bus.IorD     = ctrl.iord;
    assign bus.MemRead  = ctrl.mem_read;
    assign bus.MemWrite = ctrl.mem_write;
    assign bus.IRWrite  = ctrl.ir_write;
    assign bus.MemtoReg = ctrl.mem_to_reg;
    assign bus.RegDst   = ctrl.reg_dst;
    assign bus.RegWrite = ctrl.reg_write;
    assign bus.ALUSrcA  = ctrl.alu_src_a;
    assign bus.ALUSrcB  = ctrl.alu_src_b;
    assign bus.ALUOp    = ctrl.alu_op;
    assign bus.PCSrc    = ctrl.pc_src;
    assign state_o      = state;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    assign illegal_op   = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: randomized instruction streams checked cycle-by-cycle against a per-instruction phase model.
module tb_multicycle_ctrl;
    import mips_ctrl_pkg::*;

    typedef struct packed {
        logic [3:0]  st;
        logic [15:0] ctl;
        logic        ill;
        logic [31:0] ret;
    } snap_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] retired;
    logic [3:0]  state_o;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
    logic        illegal_op;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_ret = 0;
    snap_t       obs[$];
    snap_t       expq[$];

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.CNT_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .retired    (retired),
        .state_o    (state_o)
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        ,
        .illegal_op (illegal_op)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ctl_now();
        return {bus.PCWrite, bus.Branch, bus.IorD, bus.MemRead, bus.MemWrite, bus.IRWrite,
                bus.MemtoReg, bus.RegDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSrc};
    endfunction

    function automatic snap_t snap();
        logic ill;
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        ill = illegal_op;
`else
        ill = 1'b0;
`endif
        return {state_o, ctl_now(), ill, retired};
    endfunction

    // Control word each state must present, straight from the state table:
    // {PCWrite,Branch,IorD,MemRead,MemWrite,IRWrite,MemtoReg,RegDst,RegWrite,ALUSrcA,ALUSrcB,ALUOp,PCSrc}
    function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr);
        case (st)
            S_FETCH:            return {mr, 2'b00, 1'b1, 1'b0, mr, 4'b0000, 2'b01, 2'b00, 2'b00};
            S_DECODE:           return {10'b0, 2'b11, 4'b0000};
            S_MEMADR, S_ADDIEX: return {9'b0, 1'b1, 2'b10, 4'b0000};
            S_MEMRD:            return {2'b00, 1'b1, 1'b1, 6'b0, 6'b0};
            S_MEMWB:            return {6'b0, 1'b1, 1'b0, 1'b1, 1'b0, 6'b0};
            S_MEMWR:            return {2'b00, 1'b1, 1'b0, 1'b1, 5'b0, 6'b0};
            S_EXEC:             return {9'b0, 1'b1, 2'b00, 2'b10, 2'b00};
            S_ALUWB:            return {7'b0, 1'b1, 1'b1, 1'b0, 6'b0};
            S_ADDIWB:           return {8'b0, 1'b1, 1'b0, 6'b0};
            S_BEQ:              return {1'b0, 1'b1, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01};
            S_JUMP:             return {1'b1, 9'b0, 4'b0000, 2'b10};
            default:            return 16'h0;
        endcase
    endfunction

    // Drive one instruction through its phases (f fetch stalls, m memory stalls) and record observations.
    task automatic run_instr(input logic [5:0] op, input int f, input int m);
        logic [4:0] s[$];
        for (int i = 0; i <= f; i++) s.push_back({S_FETCH, i == f});
        s.push_back({S_DECODE, 1'($urandom)});
        case (op)
            OP_LW: begin
                s.push_back({S_MEMADR, 1'($urandom)});
                for (int i = 0; i <= m; i++) s.push_back({S_MEMRD, i == m});
                s.push_back({S_MEMWB, 1'($urandom)});
            end
            OP_SW: begin
                s.push_back({S_MEMADR, 1'($urandom)});
                for (int i = 0; i <= m; i++) s.push_back({S_MEMWR, i == m});
            end
            OP_RTYPE: begin
                s.push_back({S_EXEC, 1'($urandom)});
                s.push_back({S_ALUWB, 1'($urandom)});
            end
            OP_ADDI: begin
                s.push_back({S_ADDIEX, 1'($urandom)});
                s.push_back({S_ADDIWB, 1'($urandom)});
            end
            OP_BEQ: s.push_back({S_BEQ, 1'($urandom)});
            OP_J:   s.push_back({S_JUMP, 1'($urandom)});
            default: ;
        endcase
        foreach (s[i]) begin
            @(negedge clk);
            bus.mem_ready = s[i][0];
            bus.opcode = (s[i][4:1] == S_FETCH) ? 6'($urandom) : op;
            #1;
            obs.push_back(snap());
            expq.push_back({s[i][4:1], exp_ctrl(s[i][4:1], s[i][0]), 1'b0, exp_ret});
        end
        if (op inside {OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J}) exp_ret = exp_ret + 1;
    endtask

    task automatic test_reset();
        bus.mem_ready = 1'b1;
        bus.opcode = OP_LW;
        #12;
        checks++;
        if (state_o !== 4'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state_o); end
        checks++;
        if (ctl_now() !== 16'h0) begin errors++; $display("FAIL reset_ctl got %h exp 0000", ctl_now()); end
        checks++;
        if (retired !== 32'd0) begin errors++; $display("FAIL reset_retired got %0d exp 0", retired); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (state_o !== S_IDLE || ctl_now() !== 16'h0) begin
            errors++; $display("FAIL idle_after_release got st=%0d ctl=%h exp st=0 ctl=0000", state_o, ctl_now());
        end
    endtask

    task automatic test_lw();
        obs.delete(); expq.delete();
        run_instr(OP_LW, 0, 0);
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL lw cyc%0d got st=%0d ctl=%h ill=%b ret=%0d exp st=%0d ctl=%h ill=%b ret=%0d", i,
                         obs[i].st, obs[i].ctl, obs[i].ill, obs[i].ret, expq[i].st, expq[i].ctl, expq[i].ill, expq[i].ret);
            end
        end
    endtask

    task automatic test_fetch_stall();
        obs.delete(); expq.delete();
        run_instr(OP_ADDI, 2, 0);
        run_instr(OP_SW, 1, 2);
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL fetch_stall cyc%0d got st=%0d ctl=%h ill=%b ret=%0d exp st=%0d ctl=%h ill=%b ret=%0d", i,
                         obs[i].st, obs[i].ctl, obs[i].ill, obs[i].ret, expq[i].st, expq[i].ctl, expq[i].ill, expq[i].ret);
            end
        end
    endtask

    task automatic test_beq();
        obs.delete(); expq.delete();
        run_instr(OP_BEQ, 0, 0);
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL beq cyc%0d got st=%0d ctl=%h ill=%b ret=%0d exp st=%0d ctl=%h ill=%b ret=%0d", i,
                         obs[i].st, obs[i].ctl, obs[i].ill, obs[i].ret, expq[i].st, expq[i].ctl, expq[i].ill, expq[i].ret);
            end
        end
    endtask

    task automatic test_jump_rtype();
        obs.delete(); expq.delete();
        run_instr(OP_J, 0, 0);
        run_instr(OP_RTYPE, 0, 0);
        run_instr(OP_LW, 0, 3);
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL jump_rtype cyc%0d got st=%0d ctl=%h ill=%b ret=%0d exp st=%0d ctl=%h ill=%b ret=%0d", i,
                         obs[i].st, obs[i].ctl, obs[i].ill, obs[i].ret, expq[i].st, expq[i].ctl, expq[i].ill, expq[i].ret);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops[7];
        int n;
        ops = '{OP_LW, OP_SW, OP_RTYPE, OP_ADDI, OP_BEQ, OP_J, 6'h3f};
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        n = 5;
`else
        n = 6;
`endif
        obs.delete(); expq.delete();
        for (int k = 0; k < 60; k++)
            run_instr(ops[$urandom_range(0, n)], int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL random cyc%0d got st=%0d ctl=%h ill=%b ret=%0d exp st=%0d ctl=%h ill=%b ret=%0d", i,
                         obs[i].st, obs[i].ctl, obs[i].ill, obs[i].ret, expq[i].st, expq[i].ctl, expq[i].ill, expq[i].ret);
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk); bus.mem_ready = 1'b1; bus.opcode = 6'($urandom);
        @(negedge clk); bus.opcode = OP_SW;
        @(negedge clk); bus.mem_ready = 1'($urandom);
        @(negedge clk); bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (state_o !== S_MEMWR || bus.MemWrite !== 1'b1) begin
            errors++; $display("FAIL memwr_entry got st=%0d MemWrite=%b exp st=%0d MemWrite=1", state_o, bus.MemWrite, S_MEMWR);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (state_o !== S_IDLE) begin errors++; $display("FAIL async_state got %0d exp 0", state_o); end
        checks++;
        if (bus.MemWrite !== 1'b0 || ctl_now() !== 16'h0) begin
            errors++; $display("FAIL async_strobe got MemWrite=%b ctl=%h exp 0", bus.MemWrite, ctl_now());
        end
        checks++;
        if (retired !== 32'd0) begin errors++; $display("FAIL async_retired got %0d exp 0", retired); end
        exp_ret = 0;
        @(negedge clk);
        rst_n = 1'b1;
        obs.delete(); expq.delete();
        run_instr(OP_BEQ, 0, 0);
        run_instr(OP_ADDI, 0, 0);
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL after_reset cyc%0d got st=%0d ctl=%h ill=%b ret=%0d exp st=%0d ctl=%h ill=%b ret=%0d", i,
                         obs[i].st, obs[i].ctl, obs[i].ill, obs[i].ret, expq[i].st, expq[i].ctl, expq[i].ill, expq[i].ret);
            end
        end
    endtask

    task automatic test_illegal();
`ifdef MCCTRL_ILLEGAL_TRAP_EN
        @(negedge clk); bus.mem_ready = 1'b1; bus.opcode = 6'($urandom);
        @(negedge clk); bus.opcode = 6'h3f;
        #1;
        checks++;
        if (state_o !== S_DECODE || illegal_op !== 1'b0) begin
            errors++; $display("FAIL trap_decode got st=%0d ill=%b exp st=%0d ill=0", state_o, illegal_op, S_DECODE);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            bus.mem_ready = 1'($urandom);
            bus.opcode = (i < 5) ? 6'h3f : OP_J;
            #1;
            checks++;
            if (state_o !== S_TRAP || illegal_op !== 1'b1 || ctl_now() !== 16'h0 || retired !== exp_ret) begin
                errors++;
                $display("FAIL trap cyc%0d got st=%0d ill=%b ctl=%h ret=%0d exp st=%0d ill=1 ctl=0000 ret=%0d",
                         i, state_o, illegal_op, ctl_now(), retired, S_TRAP, exp_ret);
            end
        end
`else
        obs.delete(); expq.delete();
        run_instr(6'h3f, 0, 0);
        run_instr(6'h3f, 1, 0);
        run_instr(OP_J, 0, 0);
        run_instr(OP_RTYPE, 0, 0);
        foreach (obs[i]) begin
            checks++;
            if (obs[i] !== expq[i]) begin
                errors++;
                $display("FAIL illegal_nop cyc%0d got st=%0d ctl=%h ill=%b ret=%0d exp st=%0d ctl=%h ill=%b ret=%0d", i,
                         obs[i].st, obs[i].ctl, obs[i].ill, obs[i].ret, expq[i].st, expq[i].ctl, expq[i].ill, expq[i].ret);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_lw();
        test_fetch_stall();
        test_beq();
        test_jump_rtype();
        test_random();
        test_async_reset();
        test_illegal();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Moore FSM controller that sequences a multi-cycle MIPS datapath: shared ALU, single unified memory, instruction register (IR), and A/B/ALUOut holding registers.
- Supports R-type, addi, lw, sw, beq and j.
- Stalls on a memory-ready handshake.
- Counts retired instructions.
- Sits beside the datapath and drives every mux select and write strobe from the IR opcode.

Parameters:
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
opcode  in  6  IR[31:26], valid from DECODE onward
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
Branch  out  1  conditional PC load (PC loads when Branch & Zero)
IorD  out  1  memory address: 0=PC, 1=ALUOut
MemRead  out  1  memory read request
MemWrite  out  1  memory write request
IRWrite  out  1  IR load
MemtoReg  out  1  register write data: 0=ALUOut, 1=MDR
RegDst  out  1  write register: 0=rt, 1=rd
RegWrite  out  1  register file write
ALUSrcA  out  1  0=PC, 1=A
ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2
ALUOp  out  2  00=add, 01=sub, 10=funct-decoded
PCSrc  out  2  00=ALU result, 01=ALUOut, 10=jump target
retired  out  CNT_W  instructions completed, wraps modulo 2^CNT_W
state_o  out  4  current state encoding, for debug

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; retired=0.
- All outputs are 0 in IDLE.
- IDLE -> FETCH unconditionally on the first clock after reset release.
- Moore outputs. Any output not listed for a state is 0. ALUSrcB/ALUOp/PCSrc default to 00.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite and PCWrite = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut). Next state by opcode:
  - 100011/101011 -> MEMADR
  - 000000 -> EXEC
  - 001000 -> ADDIEX
  - 000100 -> BEQ
  - 000010 -> JUMP
  - other -> see Optional Feature
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Next is MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Hold while mem_ready=0; on mem_ready=1 -> MEMWB.
- MEMWB: RegWrite=1, MemtoReg=1, RegDst=0 -> FETCH.
- MEMWR: MemWrite=1, IorD=1. Hold while mem_ready=0; on mem_ready=1 -> FETCH.
- EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB.
- ALUWB: RegWrite=1, RegDst=1, MemtoReg=0 -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB.
- ADDIWB: RegWrite=1, RegDst=0 -> FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01 -> FETCH.
- JUMP: PCWrite=1, PCSrc=10 -> FETCH.
- retired increments by 1 on the final-state clock edge of each instruction: MEMWB, MEMWR with mem_ready, ALUWB, ADDIWB, BEQ, JUMP. Rolls all-ones -> 0.
- Cycle counts with mem_ready tied high: lw 5; sw, R-type and addi 4; beq and j 3.
- mem_ready is ignored in all states except FETCH, MEMRD and MEMWR.
- Reset mid-instruction aborts immediately to IDLE. No partial strobe is issued after rst_n falls.

Optional Feature:
- Macro: MCCTRL_ILLEGAL_TRAP_EN.
- Defined: an undefined opcode in DECODE -> TRAP state.
  - TRAP asserts only illegal_op (extra 1-bit output port).
  - TRAP is absorbing until reset; retired does not increment.
- Undefined: an undefined opcode in DECODE -> FETCH as a no-op.
  - retired does not increment.
  - The illegal_op port is absent.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - 4-bit state encodings;
  - opcode constants OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J;
  - ALUOp codes, ALUSrcB codes, PCSrc codes.
- One natural sub-module: multicycle_ctrl_outdec, a purely combinational state -> control-word decoder.
- Next-state logic and the counter stay in the top module.

Test Plan:
- lw (opcode 100011), mem_ready=1 -> states IDLE,FETCH,DECODE,MEMADR,MEMRD,MEMWB,FETCH; MemtoReg=RegWrite=1 in MEMWB only; retired 0->1.
- FETCH with mem_ready low for 2 cycles then high -> 3 FETCH cycles; IRWrite=PCWrite=1 only on the third; MemRead=1 all three.
- beq (000100) -> 3 cycles; in BEQ: ALUOp=01, Branch=1, PCSrc=01, PCWrite=0.
- j (000010) then R-type (000000) -> JUMP has PCWrite=1, PCSrc=10; ALUWB has RegDst=1; retired=2.
- rst_n low asynchronously during MEMWR -> state_o=IDLE and MemWrite=0 before the next clock edge; retired=0.
- Opcode 111111: with the macro -> TRAP, illegal_op=1 held for 10 cycles; without it -> back to FETCH after DECODE, retired unchanged.
